// File: rtl/mult_fix_pkg.sv
// Shared types and the output alignment helper for the sequential fixed-point multiplier.
// Consumers select saturation through the MULT_FIX_SEQ_SAT_EN build macro.
package mult_fix_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Working width for alignment; wide enough for any supported 2*DW product.
  localparam int MAXW = 128;

  typedef struct packed {
    logic            ovf;
    logic [MAXW-1:0] value;
  } align_t;

  // Round half-up at the bit below the kept LSB, drop `shift` fraction bits,
  // and optionally clamp into a signed dw-bit range.
  function automatic align_t round_align(
    input logic signed [MAXW-1:0] ful,
    input int                     shift,
    input int                     dw,
    input logic                   sat
  );
    logic signed [MAXW-1:0] half;
    logic signed [MAXW-1:0] rounded;
    logic signed [MAXW-1:0] lo;
    logic signed [MAXW-1:0] hi;
    align_t                 res;
    half    = (shift > 0) ? (MAXW'(1) << (shift - 1)) : '0;
    rounded = (ful + half) >>> shift;
    lo      = '1;
    lo      = lo <<< (dw - 1);
    hi      = ~lo;
    res.ovf   = 1'b0;
    res.value = rounded;
    if (sat) begin
      if (rounded > hi) begin
        res.value = hi;
        res.ovf   = 1'b1;
      end else if (rounded < lo) begin
        res.value = lo;
        res.ovf   = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mult_fix_seq_core.sv
// Radix-2 Booth sequential multiplier datapath: load latches the operands,
// each step retires one multiplier bit, done rises after DW steps.
module booth_seq_core
  import mult_fix_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [DW-1:0]        a,
  input  logic [DW-1:0]        b,
  output logic                 done,
  output logic [2*DW-1:0]      product
);

  localparam int CW = $clog2(DW + 1);

  // One guard bit so that subtracting -2^(DW-1) cannot overflow the accumulator.
  logic [DW:0]   acc;
  logic [DW:0]   mcand;
  logic [DW-1:0] mq;
  logic          q_m1;
  logic [CW-1:0] cnt;
  logic [DW:0]   sum;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    sum = acc;
    case ({mq[0], q_m1})
      2'b01:   sum = acc + mcand;
      2'b10:   sum = acc - mcand;
      default: sum = acc;
    endcase
  end

  assign done    = (cnt == CW'(DW));
  assign product = {acc[DW-1:0], mq};

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      mcand <= '0;
      mq    <= '0;
      q_m1  <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      acc   <= '0;
      mcand <= {a[DW-1], a};
      mq    <= b;
      q_m1  <= 1'b0;
      cnt   <= '0;
    end else if (step && !done) begin
      // Arithmetic shift right of {acc, mq, q_m1} after the add/subtract.
      acc   <= {sum[DW], sum[DW:1]};
      mq    <= {sum[0], mq[DW-1:1]};
      q_m1  <= mq[0];
      cnt   <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mult_fix_seq.sv
// Sequential signed fixed-point multiplier with valid/ready handshakes and a tag.
// Build macro MULT_FIX_SEQ_SAT_EN: clamp c_out and flag ovf instead of wrapping.
module mult_fix_seq
  import mult_fix_pkg::*;
#(
  parameter int DW     = 32,
  parameter int INT1_I = 16,
  parameter int INT2_I = 16,
  parameter int INT3_O = 16,
  parameter int TAGW   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [DW-1:0]   a_in,
  input  logic signed [DW-1:0]   b_in,
  input  logic [TAGW-1:0]        tag_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [DW-1:0]   c_out,
  output logic signed [2*DW-1:0] c_ful,
  output logic [TAGW-1:0]        tag_out,
  output logic                   ovf
);

  localparam int FRQ1_I = DW - INT1_I;
  localparam int FRQ2_I = DW - INT2_I;
  localparam int FRQ3_O = DW - INT3_O;
  localparam int SHIFT  = FRQ1_I + FRQ2_I - FRQ3_O;

`ifdef MULT_FIX_SEQ_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  if (INT3_O > INT1_I + INT2_I || FRQ3_O > FRQ1_I + FRQ2_I || 2 * DW >= MAXW)
  begin : g_bad_format
    $error("mult_fix_seq: output format does not fit the product format");
  end

  state_t              state;
  logic [TAGW-1:0]     tag_q;
  logic                load;
  logic                step;
  logic                core_done;
  logic [2*DW-1:0]     product;
  logic signed [MAXW-1:0] ful_ext;
  align_t              al;
  logic                ovf_next;
  logic                unused_hi;

  assign load = in_valid && in_ready;
  assign step = (state == BUSY);

  booth_seq_core #(
    .DW (DW)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .a       (a_in),
    .b       (b_in),
    .done    (core_done),
    .product (product)
  );

  assign ful_ext = {{(MAXW - 2 * DW){product[2*DW-1]}}, product};

  always_comb begin
    al = round_align(ful_ext, SHIFT, DW, SAT);
`ifdef MULT_FIX_SEQ_SAT_EN
    ovf_next = al.ovf;
`else
    ovf_next = 1'b0;
`endif
  end

  // Bits above DW are discarded: wrapped, or already clamped into range.
  assign unused_hi = ^al.value[MAXW-1:DW];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      c_out     <= '0;
      c_ful     <= '0;
      tag_out   <= '0;
      tag_q     <= '0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= BUSY;
            in_ready <= 1'b0;
            tag_q    <= tag_in;
          end
        end
        BUSY: begin
          if (core_done) begin
            state     <= DONE;
            out_valid <= 1'b1;
            c_ful     <= product;
            c_out     <= al.value[DW-1:0];
            ovf       <= ovf_next;
            tag_out   <= tag_q;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_fix_seq.sv
// Self-checking bench for mult_fix_seq (DW=16, Q8.8 in/out): arithmetic model
// plus scoreboard checked every cycle, and directed vectors with literal results.
module tb_mult_fix_seq;

  localparam int DW    = 16;
  localparam int SHIFT = 8;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic [3:0]  tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] c_out;
  logic [31:0] c_ful;
  logic [3:0]  tag_out;
  logic        ovf;

  int tests = 0;
  int fails = 0;

  mult_fix_seq #(
    .DW     (16),
    .INT1_I (8),
    .INT2_I (8),
    .INT3_O (8),
    .TAGW   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c_out     (c_out),
    .c_ful     (c_ful),
    .tag_out   (tag_out),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] ful;
    logic [15:0] cout;
    logic        ovf;
    logic [3:0]  tag;
    int          acc_cyc;
    bit          seen;
  } exp_t;

  // Exact product, then floor((p + half LSB) / 2^SHIFT), then clamp or wrap.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t);
    longint p;
    longint r;
    exp_t   e;
    p = longint'($signed(a)) * longint'($signed(b));
    r = (p + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
    e.ful = p[31:0];
    e.tag = t;
    e.acc_cyc = 0;
    e.seen = 1'b0;
`ifdef MULT_FIX_SEQ_SAT_EN
    if (r > 32767) begin
      e.cout = 16'h7FFF;
      e.ovf  = 1'b1;
    end else if (r < -32768) begin
      e.cout = 16'h8000;
      e.ovf  = 1'b1;
    end else begin
      e.cout = r[15:0];
      e.ovf  = 1'b0;
    end
`else
    e.cout = r[15:0];
    e.ovf  = 1'b0;
`endif
    return e;
  endfunction

  exp_t sb[$];
  int   cyc = 0;
  bit   chk_rst = 1'b0;

  // Compare process: inputs change just after posedge, so negedge sees stable
  // values and predicts the handshakes of the coming edge.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (chk_rst) begin
      check("reset_in_ready", in_ready, 1'b1);
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_c_out", c_out, 16'h0);
      check("reset_c_ful", c_ful, 32'h0);
      check("reset_tag_out", tag_out, 4'h0);
      check("reset_ovf", ovf, 1'b0);
    end
    chk_rst = rst;
    if (rst) begin
      sb.delete();
    end else begin
      if (sb.size() == 0) begin
        check("idle_out_valid", out_valid, 1'b0);
      end else if (!sb[0].seen) begin
        check("valid_latency", out_valid, (cyc - sb[0].acc_cyc) >= DW + 1);
        if (out_valid) sb[0].seen = 1'b1;
      end else begin
        check("valid_held", out_valid, 1'b1);
      end
      if (out_valid && sb.size() > 0) begin
        check("m_c_out", c_out, sb[0].cout);
        check("m_c_ful", c_ful, sb[0].ful);
        check("m_tag_out", tag_out, sb[0].tag);
        check("m_ovf", ovf, sb[0].ovf);
        check("m_in_ready_done", in_ready, 1'b0);
        if (out_ready) void'(sb.pop_front());
      end
      if (in_valid && in_ready) begin
        e = model(a_in, b_in, tag_in);
        e.acc_cyc = cyc + 1;
        sb.push_back(e);
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) check("send_timeout", 1'b0, 1'b1);
    a_in = a;
    b_in = b;
    tag_in = t;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency_edges", n, DW + 1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("consumed", out_valid, 1'b0);
  endtask

  task automatic op(input string name, input logic [15:0] a, input logic [15:0] b,
                    input logic [3:0] t, input logic [15:0] exp_c, input logic [31:0] exp_f,
                    input logic exp_o);
    send(a, b, t);
    wait_valid();
    check({name, "_c_out"}, c_out, exp_c);
    check({name, "_c_ful"}, c_ful, exp_f);
    check({name, "_tag"}, tag_out, t);
    check({name, "_ovf"}, ovf, exp_o);
    consume();
  endtask

  initial begin
    logic [15:0] cap_c;
    logic [31:0] cap_f;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a_in = '0;
    b_in = '0;
    tag_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("init_in_ready", in_ready, 1'b1);
    check("init_out_valid", out_valid, 1'b0);

    op("basic", 16'h0180, 16'h0200, 4'd3, 16'h0300, 32'h0003_0000, 1'b0);
    op("neg", 16'hFE80, 16'h0200, 4'd5, 16'hFD00, 32'hFFFD_0000, 1'b0);
    op("round", 16'h0001, 16'h0080, 4'd1, 16'h0001, 32'h0000_0080, 1'b0);
    op("neg_half", 16'hFFFF, 16'h0080, 4'd2, 16'h0000, 32'hFFFF_FF80, 1'b0);
    op("minus_one", 16'hFF00, 16'h0100, 4'd4, 16'hFF00, 32'hFFFF_0000, 1'b0);
`ifdef MULT_FIX_SEQ_SAT_EN
    op("ovf_pos", 16'h7F00, 16'h0200, 4'd6, 16'h7FFF, 32'h00FE_0000, 1'b1);
    op("min_min", 16'h8000, 16'h8000, 4'd7, 16'h7FFF, 32'h4000_0000, 1'b1);
    op("ovf_neg", 16'h8000, 16'h7FFF, 4'd8, 16'h8000, 32'hC000_8000, 1'b1);
`else
    op("ovf_pos", 16'h7F00, 16'h0200, 4'd6, 16'hFE00, 32'h00FE_0000, 1'b0);
    op("min_min", 16'h8000, 16'h8000, 4'd7, 16'h0000, 32'h4000_0000, 1'b0);
    op("ovf_neg", 16'h8000, 16'h7FFF, 4'd8, 16'h0080, 32'hC000_8000, 1'b0);
`endif

    // Backpressure: hold the result for 5 cycles while poking in_valid.
    send(16'h0300, 16'h0280, 4'hA);
    wait_valid();
    cap_c = c_out;
    cap_f = c_ful;
    check("bp_c_out", c_out, 16'h0780);
    check("bp_c_ful", c_ful, 32'h0007_8000);
    for (int i = 0; i < 5; i++) begin
      a_in = 16'h1111 + 16'(i);
      b_in = 16'h2222;
      tag_in = 4'hF;
      in_valid = (i % 2) == 0;
      @(posedge clk);
      #1;
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_hold_c_out", c_out, cap_c);
      check("bp_hold_c_ful", c_ful, cap_f);
      check("bp_hold_tag", tag_out, 4'hA);
      check("bp_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    consume();
    check("bp_back_idle", in_ready, 1'b1);

    // Reset asserted at the 7th Booth step edge aborts the operation.
    send(16'h0180, 16'h0200, 4'h7);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_c_out", c_out, 16'h0);
    check("rst_c_ful", c_ful, 32'h0);
    repeat (25) @(posedge clk);
    #1;
    check("rst_no_result", out_valid, 1'b0);
    op("after_rst", 16'h0200, 16'h0200, 4'hC, 16'h0400, 32'h0004_0000, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
